// File: rtl/muldiv_sched_pkg.sv
// Shared ALU package: scheduler FSM states and the mul/div function codes
// carried in bits [4:0] of the 7-bit ALU opcode.
package muldiv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  localparam logic [4:0] FN_MUL    = 5'b11000;
  localparam logic [4:0] FN_MULH   = 5'b11001;
  localparam logic [4:0] FN_MULHSU = 5'b11010;
  localparam logic [4:0] FN_MULHU  = 5'b11011;
  localparam logic [4:0] FN_DIV    = 5'b11100;
  localparam logic [4:0] FN_DIVU   = 5'b11101;
  localparam logic [4:0] FN_REM    = 5'b11110;
  localparam logic [4:0] FN_REMU   = 5'b11111;

endpackage

// File: rtl/muldiv_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// only moves when the caller reports a completed grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 means requester 1 won last, so requester 0 wins the next tie
  logic last;

  always_comb begin
    grant = '0;
    if (req[0] && (!req[1] || last)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Two-requester scheduler for a shared mul/div ALU: arbitrate, issue, wait,
// respond, with flush/drain. Optional perf counters under MULDIV_SCHED_PERF_EN.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [6:0]       req0_op,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [6:0]       req1_op,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic             alu_en,
  output logic [6:0]       alu_op,
  output logic [XLEN-1:0]  alu_in0,
  output logic [XLEN-1:0]  alu_in1,
  input  logic             alu_ready,
  input  logic             alu_valid,
  input  logic [XLEN-1:0]  alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_src,
`ifdef MULDIV_SCHED_PERF_EN
  output logic [31:0]      perf_grant0,
  output logic [31:0]      perf_grant1,
  output logic [31:0]      perf_stall,
`endif
  output logic             busy
);

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       take;
  logic       capture;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (take),
    .grant   (grant)
  );

  assign take = req0_ready | req1_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // rst_n gates the grant so no ready escapes while reset holds us in IDLE
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_en     = 1'b0;
    rsp_valid  = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rst_n && !flush && (grant != 2'b00)) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (alu_ready) begin
          alu_en    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // a result landing in the flush cycle is dropped here; nothing left to drain
        if (flush) begin
          state_nxt = alu_valid ? S_IDLE : S_DRAIN;
        end else if (alu_valid) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_DRAIN: begin
        if (alu_valid) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          rsp_valid = 1'b1;
          if (rsp_ready) begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op   <= '0;
      alu_in0  <= '0;
      alu_in1  <= '0;
      rsp_tag  <= '0;
      rsp_src  <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (take) begin
        alu_op  <= req1_ready ? req1_op  : req0_op;
        alu_in0 <= req1_ready ? req1_a   : req0_a;
        alu_in1 <= req1_ready ? req1_b   : req0_b;
        rsp_tag <= req1_ready ? req1_tag : req0_tag;
        rsp_src <= req1_ready;
      end
      if (capture) begin
        rsp_data <= alu_out;
      end
    end
  end

`ifdef MULDIV_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (req0_ready) perf_grant0 <= perf_grant0 + 32'd1;
      if (req1_ready) perf_grant1 <= perf_grant1 + 32'd1;
      if ((state == S_ISSUE) && !alu_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched (default build); inputs are
// driven at the falling edge and outputs sampled 1ns later.
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [6:0]       req0_op, req1_op;
  logic [XLEN-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             flush;
  logic             alu_en;
  logic [6:0]       alu_op;
  logic [XLEN-1:0]  alu_in0, alu_in1;
  logic             alu_ready, alu_valid;
  logic [XLEN-1:0]  alu_out;
  logic             rsp_valid, rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_src;
  logic             busy;

  int n_checks;
  int n_fail;

  muldiv_sched #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .flush(flush), .alu_en(alu_en), .alu_op(alu_op),
    .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_ready(alu_ready), .alu_valid(alu_valid), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_src(rsp_src), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far, required completion", n_fail);
    $fatal(1);
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
    flush = 1'b0; alu_ready = 1'b1; alu_valid = 1'b0; alu_out = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    nx(); #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b required 00", {req1_ready, req0_ready});
    end
    n_checks++;
    if ({busy, alu_en, rsp_valid, rsp_src} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: busy/alu_en/rsp_valid/rsp_src got %b required 0000", {busy, alu_en, rsp_valid, rsp_src});
    end
    n_checks++;
    if ({rsp_data, rsp_tag, alu_op, alu_in0, alu_in1} !== '0) begin
      n_fail++; $display("FAIL reset_data: rsp_data=%h rsp_tag=%h alu_op=%h in0=%h in1=%h required all 0", rsp_data, rsp_tag, alu_op, alu_in0, alu_in1);
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    nx();
    req0_valid = 1'b1; req0_op = 7'b0000000; req0_a = 64'd5; req0_b = 64'd7; req0_tag = 4'd3;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: got %b required 01", {req1_ready, req0_ready});
    end
    nx(); req0_valid = 1'b0; #1;
    n_checks++;
    if ({alu_en, alu_in0, alu_in1} !== {1'b1, 64'd5, 64'd7}) begin
      n_fail++; $display("FAIL single_issue: alu_en=%b in0=%0d in1=%0d required 1/5/7", alu_en, alu_in0, alu_in1);
    end
    nx(); alu_valid = 1'b1; alu_out = 64'd12; #1;
    n_checks++;
    if ({alu_en, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_wait: alu_en/rsp_valid got %b required 00", {alu_en, rsp_valid});
    end
    nx(); alu_valid = 1'b0; #1;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_src} !== {1'b1, 64'd12, 4'd3, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp: valid=%b data=%0d tag=%0d src=%b required 1/12/3/0", rsp_valid, rsp_data, rsp_tag, rsp_src);
    end
    nx(); #1;
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_done: busy/rsp_valid got %b required 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      nx();
      req0_valid = 1'b1; req0_a = 64'(i); req0_b = 64'd1; req0_tag = 4'd1;
      req1_valid = 1'b1; req1_a = 64'(i); req1_b = 64'd2; req1_tag = 4'd2;
      #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_grant[i]) begin
        n_fail++; $display("FAIL contention_grant%0d: got %b required %b", i, {req1_ready, req0_ready}, exp_grant[i]);
      end
      nx(); alu_ready = 1'b1; #1;
      nx(); alu_valid = 1'b1; alu_out = 64'(100 + i); #1;
      nx(); alu_valid = 1'b0; #1;
      n_checks++;
      if ({rsp_valid, rsp_src, rsp_tag, rsp_data} !== {1'b1, exp_grant[i][1], exp_grant[i][1] ? 4'd2 : 4'd1, 64'(100 + i)}) begin
        n_fail++; $display("FAIL contention_rsp%0d: valid=%b src=%b tag=%0d data=%0d required 1/%b/%0d/%0d", i, rsp_valid, rsp_src, rsp_tag, rsp_data, exp_grant[i][1], exp_grant[i][1] ? 2 : 1, 100 + i);
      end
    end
    nx(); req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_divide();
    int pulses = 0;
    int unstable = 0;
    int rsps = 0;
    logic [XLEN-1:0] data_seen = '0;
    req1_valid = 1'b1; req1_op = {2'b00, FN_DIV}; req1_a = 64'd100; req1_b = 64'd7; req1_tag = 4'd9;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL divide_grant: got %b required 10", {req1_ready, req0_ready});
    end
    for (int k = 0; k < 40; k++) begin
      nx();
      req1_valid = 1'b0;
      alu_ready = (k >= 2);
      alu_valid = (k == 35);
      alu_out   = (k == 35) ? 64'd14 : 64'hdead;
      #1;
      if (alu_en) pulses++;
      if (k < 36 && {alu_op, alu_in0, alu_in1} !== {2'b00, FN_DIV, 64'd100, 64'd7}) unstable++;
      if (rsp_valid) begin rsps++; data_seen = rsp_data; end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL divide_pulses: got %0d alu_en pulses required 1", pulses);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++; $display("FAIL divide_operands: got %0d unstable cycles required 0", unstable);
    end
    n_checks++;
    if ({rsps, data_seen} !== {32'd1, 64'd14}) begin
      n_fail++; $display("FAIL divide_rsp: got %0d responses data=%0d required 1/14", rsps, data_seen);
    end
    alu_ready = 1'b1;
  endtask

  task automatic test_flush();
    int bad = 0;
    // flush in IDLE must not grant
    nx(); flush = 1'b1; req0_valid = 1'b1; req0_op = '0; req0_a = 64'd1; req0_b = 64'd2; req0_tag = 4'd4; #1;
    n_checks++;
    if ({req1_ready, req0_ready, busy} !== 3'b000) begin
      n_fail++; $display("FAIL flush_idle: ready/busy got %b required 000", {req1_ready, req0_ready, busy});
    end
    nx(); flush = 1'b0; #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle_grant: got %b required 1", req0_ready);
    end
    nx(); req0_valid = 1'b0; #1;
    nx(); #1;
    nx(); flush = 1'b1; #1;
    for (int k = 0; k < 11; k++) begin
      nx(); flush = 1'b0;
      alu_valid = (k == 10); alu_out = 64'd77;
      #1;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL flush_drain: got %0d cycles not busy or with rsp_valid required 0", bad);
    end
    nx(); alu_valid = 1'b0; #1;
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL flush_drain_exit: busy/rsp_valid got %b required 00", {busy, rsp_valid});
    end
    // flush in ISSUE: no launch
    req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4; req0_tag = 4'd6;
    nx(); req0_valid = 1'b0; flush = 1'b1; #1;
    n_checks++;
    if (alu_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_issue: alu_en got %b required 0", alu_en);
    end
    nx(); flush = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_issue_exit: busy got %b required 0", busy);
    end
    // a normal request afterwards
    req0_valid = 1'b1;
    nx(); req0_valid = 1'b0; #1;
    nx(); alu_valid = 1'b1; alu_out = 64'd7; #1;
    nx(); alu_valid = 1'b0; #1;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 64'd7, 4'd6}) begin
      n_fail++; $display("FAIL flush_next: valid=%b data=%0d tag=%0d required 1/7/6", rsp_valid, rsp_data, rsp_tag);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    nx(); req0_valid = 1'b1; req0_op = '0; req0_a = 64'd20; req0_b = 64'd22; req0_tag = 4'd5; #1;
    nx(); req0_valid = 1'b0; #1;
    nx(); alu_valid = 1'b1; alu_out = 64'd42; #1;
    for (int k = 0; k < 5; k++) begin
      nx(); alu_valid = 1'b0; alu_out = '0; rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = '0; req1_a = 64'd8; req1_b = 64'd9; req1_tag = 4'd11;
      #1;
      if ({rsp_valid, rsp_data, rsp_tag, req1_ready} !== {1'b1, 64'd42, 4'd5, 1'b0}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL backpressure_hold: got %0d bad cycles required 0", bad);
    end
    nx(); rsp_ready = 1'b1; #1;
    n_checks++;
    if ({rsp_valid, rsp_data, req1_ready} !== {1'b1, 64'd42, 1'b0}) begin
      n_fail++; $display("FAIL backpressure_release: valid=%b data=%0d req1_ready=%b required 1/42/0", rsp_valid, rsp_data, req1_ready);
    end
    nx(); #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_next_grant: got %b required 1", req1_ready);
    end
    nx(); req1_valid = 1'b0; #1;
    nx(); alu_valid = 1'b1; alu_out = 64'd17; #1;
    nx(); alu_valid = 1'b0; #1;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_src} !== {1'b1, 64'd17, 4'd11, 1'b1}) begin
      n_fail++; $display("FAIL back_to_back_rsp: valid=%b data=%0d tag=%0d src=%b required 1/17/11/1", rsp_valid, rsp_data, rsp_tag, rsp_src);
    end
  endtask

  task automatic test_reset_mid();
    int rsps = 0;
    nx(); req0_valid = 1'b1; req0_op = 7'h55; req0_a = 64'd30; req0_b = 64'd40; req0_tag = 4'd12; #1;
    nx(); req0_valid = 1'b0; #1;
    nx(); #1;
    rst_n = 1'b0; req0_valid = 1'b1; #1;
    n_checks++;
    if ({busy, alu_en, rsp_valid, req0_ready, req1_ready} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_mid_ctrl: busy/alu_en/rsp_valid/ready got %b required 00000", {busy, alu_en, rsp_valid, req0_ready, req1_ready});
    end
    n_checks++;
    if ({rsp_data, rsp_tag, rsp_src, alu_op, alu_in0, alu_in1} !== '0) begin
      n_fail++; $display("FAIL reset_mid_data: rsp_data=%h tag=%h src=%b alu_op=%h in0=%h in1=%h required all 0", rsp_data, rsp_tag, rsp_src, alu_op, alu_in0, alu_in1);
    end
    nx(); req0_valid = 1'b0; rst_n = 1'b1; alu_valid = 1'b1; alu_out = 64'd70; #1;
    for (int k = 0; k < 6; k++) begin
      nx(); alu_valid = 1'b0; #1;
      if (rsp_valid) rsps++;
    end
    n_checks++;
    if (rsps !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_rsp: got %0d response cycles required 0", rsps);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_contention();
    test_single();
    test_divide();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
